duty_step_counter: RTL

DUTY_STEP_COUNTER -- requirements
Module: duty_step_counter

---
 rtl/duty_step_counter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/duty_step_counter.sv
// Saturating duty-cycle up/down counter with direction-reversal pulse; all outputs registered, one cycle after the strobe.
// Optional macro DUTY_ADAPT_STEP_EN enables adaptive step size (halve on reversal, double after a same-direction run).
module duty_step_counter #(
  parameter int WIDTH     = 6,
  parameter int RST_VAL   = 23,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 63,
  parameter int STEP_INIT = 1,
  parameter int STEP_MIN  = 1,
  parameter int STEP_MAX  = 8,
  parameter int RUN_LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             cri_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] step_o,
  output logic             sat_hi_o,
  output logic             sat_lo_o,
  output logic             rev_o
);

  if (!(MIN_VAL <= RST_VAL && RST_VAL <= MAX_VAL && MAX_VAL < (1 << WIDTH) &&
        1 <= STEP_MIN && STEP_MIN <= STEP_INIT && STEP_INIT <= STEP_MAX &&
        STEP_MAX < (1 << WIDTH) && RUN_LEN >= 1)) begin : g_bad_params
    $error("duty_step_counter: illegal parameter set");
  end

  localparam logic [WIDTH-1:0] RST_W       = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] MIN_W       = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W       = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_INIT_W = WIDTH'(STEP_INIT);
  localparam logic [WIDTH:0]   MIN_X       = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X       = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH+1:0] MIN_G       = (WIDTH+2)'(MIN_VAL);
  localparam logic [WIDTH+1:0] MAX_G       = (WIDTH+2)'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d, step_q, step_d;
  logic             dir_q, dir_d, hist_q, hist_d, rev_q, rev_d;
  logic             sat_hi_q, sat_lo_q, reversal;
  logic [WIDTH:0]   sum, floor_v;
  logic [WIDTH+1:0] lv, lo_gap, lv_lo, hi_gap;

`ifdef DUTY_ADAPT_STEP_EN
  localparam int                RUN_W      = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(RUN_LEN - 1);
  localparam logic [WIDTH-1:0]  STEP_MIN_W = WIDTH'(STEP_MIN);
  localparam logic [WIDTH-1:0]  STEP_MAX_W = WIDTH'(STEP_MAX);
  localparam logic [WIDTH:0]    STEP_MAX_X = (WIDTH+1)'(STEP_MAX);
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0] half;
  logic [WIDTH:0]   dbl;
`endif

  always_comb begin
    sum      = {1'b0, cnt_q} + {1'b0, step_q};
    floor_v  = MIN_X + {1'b0, step_q};
    // Load clamp done with two-bit headroom so the sign bit flags out-of-range values.
    lv       = {2'b00, load_val_i};
    lo_gap   = lv - MIN_G;
    lv_lo    = lo_gap[WIDTH+1] ? MIN_G : (MIN_G + lo_gap);
    hi_gap   = MAX_G - lv_lo;
    reversal = en_i && hist_q && (cri_i != dir_q);
    cnt_d    = cnt_q;
    step_d   = step_q;
    dir_d    = dir_q;
    hist_d   = hist_q;
    rev_d    = 1'b0;
`ifdef DUTY_ADAPT_STEP_EN
    half     = step_q >> 1;
    dbl      = {step_q, 1'b0};
    run_d    = run_q;
`endif
    if (rst) begin
      cnt_d  = RST_W;
      step_d = STEP_INIT_W;
      dir_d  = 1'b1;
      hist_d = 1'b0;
`ifdef DUTY_ADAPT_STEP_EN
      run_d  = '0;
`endif
    end else if (load_i) begin
      cnt_d  = hi_gap[WIDTH+1] ? MAX_W : WIDTH'(MAX_G - hi_gap);
      step_d = STEP_INIT_W;
      hist_d = 1'b0;
`ifdef DUTY_ADAPT_STEP_EN
      run_d  = '0;
`endif
    end else if (en_i) begin
      if (cri_i) cnt_d = (sum > MAX_X) ? MAX_W : sum[WIDTH-1:0];
      else       cnt_d = ({1'b0, cnt_q} < floor_v) ? MIN_W : (cnt_q - step_q);
      dir_d  = cri_i;
      hist_d = 1'b1;
      rev_d  = reversal;
`ifdef DUTY_ADAPT_STEP_EN
      if (reversal) begin
        step_d = (half < STEP_MIN_W) ? STEP_MIN_W : half;
        run_d  = '0;
      end else if (run_q == RUN_LAST) begin
        step_d = (dbl > STEP_MAX_X) ? STEP_MAX_W : dbl[WIDTH-1:0];
        run_d  = '0;
      end else begin
        run_d  = run_q + RUN_W'(1);
      end
`endif
    end
  end

  // Saturation flags come from the next-state count so they track cnt_o exactly.
  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    step_q   <= step_d;
    dir_q    <= dir_d;
    hist_q   <= hist_d;
    rev_q    <= rev_d;
    sat_hi_q <= (cnt_d == MAX_W);
    sat_lo_q <= (cnt_d == MIN_W);
`ifdef DUTY_ADAPT_STEP_EN
    run_q    <= run_d;
`endif
  end

  assign cnt_o    = cnt_q;
  assign step_o   = step_q;
  assign sat_hi_o = sat_hi_q;
  assign sat_lo_o = sat_lo_q;
  assign rev_o    = rev_q;

endmodule
